// File: rtl/issue_pair_scheduler.sv
// issue_pair_scheduler
//
// Steers each decoded instruction pair into the dual-issue ID/EX boundary.
// Every cycle it decides whether the pair issues together, splits across two
// cycles (slot 0 first, slot 1 next), or holds for a load-use bubble. A small
// tracker remembers the load destinations issued in the last accepted cycle,
// so the decode-stage forwarding network never needs EX-stage load data.
//
// Ports
//   clk, rst_n                 clock, synchronous active-low reset
//   flush                      redirect; kills the current pair
//   in_valid / in_ready        decoded pair handshake (in_ready = pair consumed)
//   in_vld_k                   slot k holds a real instruction (k = 0,1)
//   in_rs1_k, in_rs2_k, in_rd_k
//                              slot k register addresses
//   in_rdwen_k, in_ismem_k, in_isbr_k, in_isld_k
//                              slot k write-back / memory / branch / load flags
//   out_ready                  IDEX accepts this cycle
//   iss_vld_0, iss_vld_1       lane valids
//   iss_src                    0: lane 0 = slot 0, 1: lane 0 = slot 1
//   sched_ldstall              load-use bubble this cycle
//   stat_dual, stat_split, stat_ldstall
//                              wrapping event counters
module issue_pair_scheduler #(
   parameter int RF_ADDR_WIDTH = 5,
   parameter int CNT_WIDTH     = 32
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     flush,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic                     in_vld_0,
   input  logic                     in_vld_1,
   input  logic [RF_ADDR_WIDTH-1:0] in_rs1_0,
   input  logic [RF_ADDR_WIDTH-1:0] in_rs2_0,
   input  logic [RF_ADDR_WIDTH-1:0] in_rd_0,
   input  logic [RF_ADDR_WIDTH-1:0] in_rs1_1,
   input  logic [RF_ADDR_WIDTH-1:0] in_rs2_1,
   input  logic [RF_ADDR_WIDTH-1:0] in_rd_1,
   input  logic                     in_rdwen_0,
   input  logic                     in_rdwen_1,
   input  logic                     in_ismem_0,
   input  logic                     in_ismem_1,
   input  logic                     in_isbr_0,
   input  logic                     in_isbr_1,
   input  logic                     in_isld_0,
   input  logic                     in_isld_1,
   input  logic                     out_ready,
   output logic                     iss_vld_0,
   output logic                     iss_vld_1,
   output logic                     iss_src,
   output logic                     sched_ldstall,
   output logic [CNT_WIDTH-1:0]     stat_dual,
   output logic [CNT_WIDTH-1:0]     stat_split,
   output logic [CNT_WIDTH-1:0]     stat_ldstall
);

   typedef enum logic {
      S_PAIR   = 1'b0,
      S_SECOND = 1'b1
   } state_t;

   localparam logic [RF_ADDR_WIDTH-1:0] X0      = '0;
   localparam logic [CNT_WIDTH-1:0]     CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

   state_t                   state_q, state_d;
   logic                     trk_vld0_q, trk_vld0_d;
   logic                     trk_vld1_q, trk_vld1_d;
   logic [RF_ADDR_WIDTH-1:0] trk_rd0_q, trk_rd0_d;
   logic [RF_ADDR_WIDTH-1:0] trk_rd1_q, trk_rd1_d;
   logic [CNT_WIDTH-1:0]     dual_q, dual_d;
   logic [CNT_WIDTH-1:0]     split_q, split_d;
   logic [CNT_WIDTH-1:0]     ldst_q, ldst_d;

   logic kill;
   logic commit;
   logic pair_valid;
   logic lu_0, lu_1;
   logic raw, waw, co;
   logic split_first;
   logic lane0_isld;
   logic [RF_ADDR_WIDTH-1:0] lane0_rd;

   // A source hits the tracker only when it is not x0 and matches a live entry.
   function automatic logic trk_hit(input logic [RF_ADDR_WIDTH-1:0] rs,
                                    input logic v0, input logic [RF_ADDR_WIDTH-1:0] r0,
                                    input logic v1, input logic [RF_ADDR_WIDTH-1:0] r1);
      return (rs != X0) && ((v0 && (rs == r0)) || (v1 && (rs == r1)));
   endfunction

   // Reset asserted mid-stream looks exactly like a flush to the outputs.
   // in_vld_0 is folded into the pair valid: a pair without slot 0 is never legal.
   assign kill       = flush || !rst_n;
   assign commit     = out_ready && !kill;
   assign pair_valid = in_valid && in_vld_0;

   assign lu_0 = trk_hit(in_rs1_0, trk_vld0_q, trk_rd0_q, trk_vld1_q, trk_rd1_q) ||
                 trk_hit(in_rs2_0, trk_vld0_q, trk_rd0_q, trk_vld1_q, trk_rd1_q);
   assign lu_1 = trk_hit(in_rs1_1, trk_vld0_q, trk_rd0_q, trk_vld1_q, trk_rd1_q) ||
                 trk_hit(in_rs2_1, trk_vld0_q, trk_rd0_q, trk_vld1_q, trk_rd1_q);

   assign raw = in_rdwen_0 && (in_rd_0 != X0) &&
                ((in_rs1_1 == in_rd_0) || (in_rs2_1 == in_rd_0));
   assign waw = in_rdwen_0 && in_rdwen_1 && (in_rd_0 == in_rd_1) && (in_rd_0 != X0);
   assign co  = !raw && !waw && !(in_ismem_0 && in_ismem_1) &&
                !(in_isbr_0 && in_isbr_1) && !lu_1;

   // Issue decision. Everything is combinational so the pair can issue in the
   // same cycle it arrives; state only advances when IDEX actually accepts.
   always_comb begin
      in_ready      = 1'b0;
      iss_vld_0     = 1'b0;
      iss_vld_1     = 1'b0;
      iss_src       = 1'b0;
      sched_ldstall = 1'b0;
      split_first   = 1'b0;
      state_d       = state_q;
      if (kill) begin
         state_d = S_PAIR;
      end else if (pair_valid) begin
         case (state_q)
            S_PAIR: begin
               if (lu_0) begin
                  sched_ldstall = 1'b1;
               end else if (!in_vld_1) begin
                  iss_vld_0 = 1'b1;
                  in_ready  = out_ready;
               end else if (co) begin
                  iss_vld_0 = 1'b1;
                  iss_vld_1 = 1'b1;
                  in_ready  = out_ready;
               end else begin
                  iss_vld_0   = 1'b1;
                  split_first = 1'b1;
                  if (out_ready) state_d = S_SECOND;
               end
            end
            S_SECOND: begin
               if (lu_1) begin
                  sched_ldstall = 1'b1;
               end else begin
                  iss_vld_0 = 1'b1;
                  iss_src   = 1'b1;
                  in_ready  = out_ready;
                  if (out_ready) state_d = S_PAIR;
               end
            end
            default: state_d = S_PAIR;
         endcase
      end
   end

   // The tracker is replaced wholesale by whatever loads issue in an accepted
   // cycle; an accepted bubble empties it, so each load costs at most one bubble.
   assign lane0_isld = iss_src ? in_isld_1 : in_isld_0;
   assign lane0_rd   = iss_src ? in_rd_1   : in_rd_0;

   always_comb begin
      trk_vld0_d = trk_vld0_q;
      trk_vld1_d = trk_vld1_q;
      trk_rd0_d  = trk_rd0_q;
      trk_rd1_d  = trk_rd1_q;
      if (kill) begin
         trk_vld0_d = 1'b0;
         trk_vld1_d = 1'b0;
      end else if (out_ready) begin
         if (iss_vld_0) begin
            trk_vld0_d = lane0_isld && (lane0_rd != X0);
            trk_rd0_d  = lane0_rd;
            trk_vld1_d = iss_vld_1 && in_isld_1 && (in_rd_1 != X0);
            trk_rd1_d  = in_rd_1;
         end else begin
            trk_vld0_d = 1'b0;
            trk_vld1_d = 1'b0;
         end
      end
   end

   // Statistics only count cycles that IDEX really takes.
   always_comb begin
      dual_d  = dual_q;
      split_d = split_q;
      ldst_d  = ldst_q;
      if (commit) begin
         if (iss_vld_0 && iss_vld_1) dual_d  = dual_q + CNT_ONE;
         if (split_first)            split_d = split_q + CNT_ONE;
         if (sched_ldstall)          ldst_d  = ldst_q + CNT_ONE;
      end
   end

   // State, tracker and counters all register here.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= S_PAIR;
         trk_vld0_q <= 1'b0;
         trk_vld1_q <= 1'b0;
         trk_rd0_q  <= '0;
         trk_rd1_q  <= '0;
         dual_q     <= '0;
         split_q    <= '0;
         ldst_q     <= '0;
      end else begin
         state_q    <= state_d;
         trk_vld0_q <= trk_vld0_d;
         trk_vld1_q <= trk_vld1_d;
         trk_rd0_q  <= trk_rd0_d;
         trk_rd1_q  <= trk_rd1_d;
         dual_q     <= dual_d;
         split_q    <= split_d;
         ldst_q     <= ldst_d;
      end
   end

   assign stat_dual    = dual_q;
   assign stat_split   = split_q;
   assign stat_ldstall = ldst_q;

endmodule

// File: tb/tb_issue_pair_scheduler.sv
// tb_issue_pair_scheduler
//
// Directed bench for issue_pair_scheduler built with 4-bit counters so the
// wrap case is reachable. A table of per-cycle records carries the inputs and
// the hand-computed outputs/counters; reset and wrap sequences follow.
module tb_issue_pair_scheduler;

   localparam int AW = 5;
   localparam int CW = 4;

   typedef struct packed {
      logic          vld;
      logic [AW-1:0] rs1;
      logic [AW-1:0] rs2;
      logic [AW-1:0] rd;
      logic          rdwen;
      logic          ismem;
      logic          isbr;
      logic          isld;
   } slot_t;

   // exp_out = {in_ready, iss_vld_0, iss_vld_1, iss_src, sched_ldstall}
   typedef struct packed {
      logic          flush;
      logic          in_valid;
      logic          out_ready;
      slot_t         s0;
      slot_t         s1;
      logic [4:0]    exp_out;
      logic [CW-1:0] exp_dual;
      logic [CW-1:0] exp_split;
      logic [CW-1:0] exp_ld;
   } vec_t;

   localparam logic [4:0] O_IDLE  = 5'b00000;
   localparam logic [4:0] O_DUAL  = 5'b11100;
   localparam logic [4:0] O_ONE   = 5'b11000;
   localparam logic [4:0] O_SPL1  = 5'b01000;
   localparam logic [4:0] O_SPL2  = 5'b11010;
   localparam logic [4:0] O_SPL2H = 5'b01010;
   localparam logic [4:0] O_STALL = 5'b00001;

   logic clk = 1'b0;
   logic rst_n;
   logic flush, in_valid, in_ready, out_ready;
   logic in_vld_0, in_vld_1;
   logic [AW-1:0] in_rs1_0, in_rs2_0, in_rd_0, in_rs1_1, in_rs2_1, in_rd_1;
   logic in_rdwen_0, in_rdwen_1, in_ismem_0, in_ismem_1;
   logic in_isbr_0, in_isbr_1, in_isld_0, in_isld_1;
   logic iss_vld_0, iss_vld_1, iss_src, sched_ldstall;
   logic [CW-1:0] stat_dual, stat_split, stat_ldstall;

   int n_checks = 0;
   int n_fail   = 0;
   vec_t vecs[$];

   always #5 clk = ~clk;

   issue_pair_scheduler #(.RF_ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_vld_0(in_vld_0), .in_vld_1(in_vld_1),
      .in_rs1_0(in_rs1_0), .in_rs2_0(in_rs2_0), .in_rd_0(in_rd_0),
      .in_rs1_1(in_rs1_1), .in_rs2_1(in_rs2_1), .in_rd_1(in_rd_1),
      .in_rdwen_0(in_rdwen_0), .in_rdwen_1(in_rdwen_1),
      .in_ismem_0(in_ismem_0), .in_ismem_1(in_ismem_1),
      .in_isbr_0(in_isbr_0), .in_isbr_1(in_isbr_1),
      .in_isld_0(in_isld_0), .in_isld_1(in_isld_1),
      .out_ready(out_ready),
      .iss_vld_0(iss_vld_0), .iss_vld_1(iss_vld_1), .iss_src(iss_src),
      .sched_ldstall(sched_ldstall),
      .stat_dual(stat_dual), .stat_split(stat_split), .stat_ldstall(stat_ldstall)
   );

   // Instruction builders for the table.
   function automatic slot_t nop();
      return '0;
   endfunction

   function automatic slot_t alu(input int rd, input int rs1, input int rs2);
      return '{vld: 1'b1, rs1: AW'(rs1), rs2: AW'(rs2), rd: AW'(rd),
               rdwen: 1'b1, ismem: 1'b0, isbr: 1'b0, isld: 1'b0};
   endfunction

   function automatic slot_t ld(input int rd, input int rs1);
      return '{vld: 1'b1, rs1: AW'(rs1), rs2: '0, rd: AW'(rd),
               rdwen: 1'b1, ismem: 1'b1, isbr: 1'b0, isld: 1'b1};
   endfunction

   function automatic slot_t st(input int rs1, input int rs2);
      return '{vld: 1'b1, rs1: AW'(rs1), rs2: AW'(rs2), rd: '0,
               rdwen: 1'b0, ismem: 1'b1, isbr: 1'b0, isld: 1'b0};
   endfunction

   function automatic slot_t br(input int rs1, input int rs2);
      return '{vld: 1'b1, rs1: AW'(rs1), rs2: AW'(rs2), rd: '0,
               rdwen: 1'b0, ismem: 1'b0, isbr: 1'b1, isld: 1'b0};
   endfunction

   task automatic add(input logic fl, input logic v, input logic ordy,
                      input slot_t s0, input slot_t s1, input logic [4:0] o,
                      input int d, input int s, input int l);
      vec_t t;
      t.flush = fl; t.in_valid = v; t.out_ready = ordy;
      t.s0 = s0; t.s1 = s1; t.exp_out = o;
      t.exp_dual = CW'(d); t.exp_split = CW'(s); t.exp_ld = CW'(l);
      vecs.push_back(t);
   endtask

   task automatic applyStimulus(input logic fl, input logic v, input logic ordy,
                                input slot_t s0, input slot_t s1);
      flush = fl; in_valid = v; out_ready = ordy;
      in_vld_0 = s0.vld; in_rs1_0 = s0.rs1; in_rs2_0 = s0.rs2; in_rd_0 = s0.rd;
      in_rdwen_0 = s0.rdwen; in_ismem_0 = s0.ismem; in_isbr_0 = s0.isbr; in_isld_0 = s0.isld;
      in_vld_1 = s1.vld; in_rs1_1 = s1.rs1; in_rs2_1 = s1.rs2; in_rd_1 = s1.rd;
      in_rdwen_1 = s1.rdwen; in_ismem_1 = s1.ismem; in_isbr_1 = s1.isbr; in_isld_1 = s1.isld;
   endtask

   task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic checkAll(input string tag, input logic [4:0] o,
                           input logic [CW-1:0] d, input logic [CW-1:0] s, input logic [CW-1:0] l);
      checkOutput({tag, " outs"}, 8'({in_ready, iss_vld_0, iss_vld_1, iss_src, sched_ldstall}), 8'(o));
      checkOutput({tag, " stat_dual"}, 8'(stat_dual), 8'(d));
      checkOutput({tag, " stat_split"}, 8'(stat_split), 8'(s));
      checkOutput({tag, " stat_ldstall"}, 8'(stat_ldstall), 8'(l));
   endtask

   // Table of single-cycle records; counters are the values seen before each
   // cycle's edge, i.e. the sum of all earlier committed events.
   initial begin
      add(0, 0, 1, nop(), nop(), O_IDLE, 0, 0, 0);
      add(0, 1, 1, alu(5, 1, 2), alu(6, 3, 4), O_DUAL, 0, 0, 0);
      add(0, 0, 1, nop(), nop(), O_IDLE, 1, 0, 0);
      add(0, 1, 1, alu(7, 1, 2), alu(10, 7, 3), O_SPL1, 1, 0, 0);
      add(0, 1, 1, alu(7, 1, 2), alu(10, 7, 3), O_SPL2, 1, 1, 0);
      add(0, 1, 1, ld(8, 1), nop(), O_ONE, 1, 1, 0);
      add(0, 1, 1, alu(11, 8, 2), alu(12, 3, 4), O_STALL, 1, 1, 0);
      add(0, 1, 1, alu(11, 8, 2), alu(12, 3, 4), O_DUAL, 1, 1, 1);
      add(0, 1, 1, st(1, 2), st(3, 4), O_SPL1, 2, 1, 1);
      add(0, 1, 1, st(1, 2), st(3, 4), O_SPL2, 2, 2, 1);
      add(0, 1, 1, br(1, 2), br(3, 4), O_SPL1, 2, 2, 1);
      add(0, 1, 1, br(1, 2), br(3, 4), O_SPL2, 2, 3, 1);
      add(0, 1, 1, alu(9, 1, 2), alu(9, 3, 4), O_SPL1, 2, 3, 1);
      add(0, 1, 1, alu(9, 1, 2), alu(9, 3, 4), O_SPL2, 2, 4, 1);
      add(0, 1, 1, alu(0, 1, 2), alu(14, 0, 3), O_DUAL, 2, 4, 1);
      // load with dependent slot 1 in the same pair: split, bubble, issue
      add(0, 1, 1, ld(15, 1), alu(16, 15, 2), O_SPL1, 3, 4, 1);
      add(0, 1, 1, ld(15, 1), alu(16, 15, 2), O_STALL, 3, 5, 1);
      add(0, 1, 1, ld(15, 1), alu(16, 15, 2), O_SPL2, 3, 5, 2);
      // load in lane 1 feeding next pair's slot 0, then slot 1
      add(0, 1, 1, alu(17, 1, 2), ld(18, 3), O_DUAL, 3, 5, 2);
      add(0, 1, 1, alu(21, 18, 1), alu(22, 2, 3), O_STALL, 4, 5, 2);
      add(0, 1, 1, alu(21, 18, 1), alu(22, 2, 3), O_DUAL, 4, 5, 3);
      add(0, 1, 1, alu(17, 1, 2), ld(18, 3), O_DUAL, 5, 5, 3);
      add(0, 1, 1, alu(19, 1, 2), alu(20, 18, 3), O_SPL1, 6, 5, 3);
      add(0, 1, 1, alu(19, 1, 2), alu(20, 18, 3), O_SPL2, 6, 6, 3);
      // back-pressure in S_SECOND with a live tracker entry
      add(0, 1, 1, ld(23, 1), alu(24, 23, 3), O_SPL1, 6, 6, 3);
      add(0, 1, 0, ld(23, 1), alu(24, 23, 3), O_STALL, 6, 7, 3);
      add(0, 1, 0, ld(23, 1), alu(24, 23, 3), O_STALL, 6, 7, 3);
      add(0, 1, 0, ld(23, 1), alu(24, 23, 3), O_STALL, 6, 7, 3);
      add(0, 1, 1, ld(23, 1), alu(24, 23, 3), O_STALL, 6, 7, 3);
      add(0, 1, 0, ld(23, 1), alu(24, 23, 3), O_SPL2H, 6, 7, 4);
      add(0, 1, 1, ld(23, 1), alu(24, 23, 3), O_SPL2, 6, 7, 4);
      // flush drops the pending slot 1
      add(0, 1, 1, alu(25, 1, 2), alu(26, 25, 3), O_SPL1, 6, 7, 4);
      add(1, 1, 1, alu(25, 1, 2), alu(26, 25, 3), O_IDLE, 6, 8, 4);
      add(0, 1, 1, alu(27, 1, 2), alu(28, 3, 4), O_DUAL, 6, 8, 4);
      // flush clears the tracker even while IDEX is stalled
      add(0, 1, 1, ld(29, 1), nop(), O_ONE, 7, 8, 4);
      add(1, 1, 0, alu(30, 29, 2), nop(), O_IDLE, 7, 8, 4);
      add(0, 1, 1, alu(30, 29, 2), nop(), O_ONE, 7, 8, 4);
      add(0, 0, 1, nop(), nop(), O_IDLE, 7, 8, 4);
   end

   initial begin
      rst_n = 1'b0;
      applyStimulus(0, 0, 1, nop(), nop());
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      foreach (vecs[i]) begin
         applyStimulus(vecs[i].flush, vecs[i].in_valid, vecs[i].out_ready, vecs[i].s0, vecs[i].s1);
         @(negedge clk);
         checkAll($sformatf("vec%0d", i), vecs[i].exp_out,
                  vecs[i].exp_dual, vecs[i].exp_split, vecs[i].exp_ld);
         @(posedge clk);
         #1;
      end

      // Reset in the middle of a split: outputs die, counters and state clear.
      applyStimulus(0, 1, 1, alu(31, 1, 2), alu(1, 31, 3));
      @(negedge clk);
      checkAll("pre_reset", O_SPL1, 4'd7, 4'd8, 4'd4);
      @(posedge clk);
      #1 rst_n = 1'b0;
      @(negedge clk);
      checkOutput("reset outs", 8'({in_ready, iss_vld_0, iss_vld_1, iss_src, sched_ldstall}), 8'(O_IDLE));
      @(posedge clk);
      #1 rst_n = 1'b1;
      applyStimulus(0, 1, 0, alu(31, 1, 2), alu(1, 31, 3));
      @(negedge clk);
      checkAll("post_reset", O_SPL1, 4'd0, 4'd0, 4'd0);
      @(posedge clk);
      #1;

      // 2^CW dual issues take stat_dual all the way round to zero.
      applyStimulus(0, 1, 1, alu(5, 1, 2), alu(6, 3, 4));
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         checkOutput($sformatf("wrap%0d stat_dual", i), 8'(stat_dual), 8'(i));
         @(posedge clk);
         #1;
      end
      @(negedge clk);
      checkAll("wrapped", O_DUAL, 4'd0, 4'd0, 4'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/issue_pair_scheduler.md
# issue_pair_scheduler

Sequences each decoded instruction pair into the dual-issue ID/EX boundary, ahead of the decode-stage operand forwarding network. It decides per cycle whether the pair issues together, is split across two cycles, or is held for a load-use bubble. It tracks loads issued in the previous accepted cycle, so the forwarding mux never needs EX-stage load data. It also keeps issue statistics counters.

## Interface
- RF_ADDR_WIDTH, 5, register address width
- CNT_WIDTH, 32, statistics counter width
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset, synchronous, active-low
- flush  in  1  branch/exception redirect; kills the current pair
- in_valid  in  1  decoded pair present
- in_ready  out  1  pair fully consumed this cycle
- in_vld_k (k=0,1)  in  1  slot k holds a real instruction; in_vld_0=0 with in_valid=1 is illegal
- in_rs1_k, in_rs2_k, in_rd_k  in  RF_ADDR_WIDTH each  slot k source/dest addresses
- in_rdwen_k, in_ismem_k, in_isbr_k, in_isld_k  in  1 each  write-back, memory op, branch, load flags
- out_ready  in  1  IDEX accepts this cycle (not stalled)
- iss_vld_0, iss_vld_1  out  1 each  lane 0 / lane 1 carry a valid instruction
- iss_src  out  1  0: lane 0 = input slot 0; 1: lane 0 = input slot 1 (split second half); lane 1 is always input slot 1
- sched_ldstall  out  1  bubble inserted for load-use this cycle
- stat_dual, stat_split, stat_ldstall  out  CNT_WIDTH each  event counters

## Operation
- State S_PAIR (fresh pair) or S_SECOND (slot 0 already issued, slot 1 pending).
- Load tracker: up to two entries {valid, rd}, loaded on an accepted issue with the rd of each issued lane that has isld=1 and rd≠0. On an accepted cycle with no issue (out_ready=1 and iss_vld_0=0), both entries are cleared. When out_ready=0, the tracker holds.
- An instruction has a load-use hazard (LU) if a nonzero rs1 or rs2 equals a valid tracker rd.
- Slot 1 may co-issue (CO) only if all of the following hold:
  - no RAW: rdwen_0, rd_0≠0, and rs1_1 or rs2_1 equal to rd_0 is a conflict;
  - no WAW: both rdwen with rd_0=rd_1≠0 is a conflict;
  - not both ismem;
  - not both isbr;
  - slot 1 is not LU.
- S_PAIR with in_valid:
  - slot 0 LU → no issue, sched_ldstall=1.
  - else if in_vld_1=0 → lane 0 = slot 0, in_ready=out_ready.
  - else if CO → both lanes valid, in_ready=out_ready.
  - else → lane 0 = slot 0 only; go to S_SECOND on out_ready.
- S_SECOND (in_valid stays asserted; the upstream holds the pair until in_ready):
  - slot 1 LU → bubble, sched_ldstall=1.
  - else → lane 0 = slot 1 (iss_src=1), iss_vld_1=0, in_ready=out_ready; return to S_PAIR on out_ready.
- flush has priority over everything:
  - iss_vld_*=0, in_ready=0, sched_ldstall=0;
  - next state S_PAIR, tracker cleared, counters unaffected.
- Counters increment only on out_ready=1 and no flush, wrapping at 2^CNT_WIDTH:
  - stat_dual on a dual issue;
  - stat_split when a split's first half issues;
  - stat_ldstall on each sched_ldstall cycle.
- Register x0 never creates a hazard or a tracker entry.

## Timing
- Issue decision is combinational from inputs, state, and tracker, with zero-cycle latency. State, tracker, and counters are registered.
- Outputs are valid while out_ready=0 but are not committed. Repeating the same inputs yields the same outputs.
- Reset: state S_PAIR, tracker empty, all counters 0. With in_valid=0, all combinational outputs are 0.
- A load in lane 0 or 1 followed by a dependent instruction in the next pair costs exactly one bubble cycle.
- A dependent slot 1 behind a load slot 0 in the same pair:
  - split (RAW) first;
  - then one bubble (LU);
  - then issue, for 3 cycles total.
- flush in S_SECOND drops the pending slot 1. Reset mid-operation behaves identically to flush and also clears the counters.

## Test plan
- Independent ALU pair (rd 5, rd 6, sources 1–4), out_ready=1 → iss_vld_0=iss_vld_1=1, iss_src=0, in_ready=1, stat_dual=1.
- Pair with rd_0=7 and rs1_1=7 → cycle 1: lane 0 only with iss_src=0 and in_ready=0. Cycle 2: lane 0 with iss_src=1 and in_ready=1. stat_split=1.
- Load x8 issued alone, next pair slot 0 reads x8 → one cycle of sched_ldstall=1 with no issue, then a dual issue. stat_ldstall=1.
- Two mem ops, then two branches, then WAW on rd 9 → each pair splits into 2 cycles. An x0 RAW (rd_0=0, rs1_1=0) dual-issues.
- out_ready=0 for 3 cycles during S_SECOND → outputs held and tracker unchanged, then completion on release. flush in S_SECOND → next cycle S_PAIR with the new pair issued from slot 0.
- stat counters preset near wrap via 2^CNT_WIDTH−1 dual issues (CNT_WIDTH=4 build) → counter wraps to 0. Reset mid-stream zeroes all counters and outputs.
